// File: rtl/branch_predict_unit.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit counters,
// trained by resolved outcomes, with a flush/redirect FSM on mispredict.
module branch_predict_unit #(
  parameter int IDX_BITS     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_pred_taken,
  input  logic [31:0] resolve_pred_target,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] mispredict_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;
  localparam int CW      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] FC_LAST = CW'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     fcnt_q, fcnt_d;
  logic [31:0]       rpc_q, rpc_d;
  logic [31:0]       mcnt_q, mcnt_d;

  logic              valid_q [ENTRIES];
  logic              valid_d [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [TAG_W-1:0]  tag_d   [ENTRIES];
  logic [31:0]       tgt_q   [ENTRIES];
  logic [31:0]       tgt_d   [ENTRIES];
  logic [1:0]        ctr_q   [ENTRIES];
  logic [1:0]        ctr_d   [ENTRIES];

  logic [IDX_BITS-1:0] f_idx, r_idx;
  logic [TAG_W-1:0]    f_tag, r_tag;
  logic                f_hit, r_hit;
  logic                accept, mispredict;

  assign f_idx = fetch_pc[IDX_BITS+1:2];
  assign f_tag = fetch_pc[31:IDX_BITS+2];
  assign r_idx = resolve_pc[IDX_BITS+1:2];
  assign r_tag = resolve_pc[31:IDX_BITS+2];

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

  // Lookup reads the registered table only: no same-cycle bypass.
  assign pred_taken  = !rst && f_hit && ctr_q[f_idx][1];
  assign pred_target = pred_taken ? tgt_q[f_idx] : fetch_pc + 32'd4;

  // Resolves arriving while flushing are wrong-path and ignored.
  assign accept     = resolve_valid && (state_q == IDLE);
  assign mispredict = accept &&
                      ((resolve_taken != resolve_pred_taken) ||
                       (resolve_taken &&
                        (resolve_target != resolve_pred_target)));

  assign flush          = (state_q == FLUSH);
  assign redirect_valid = flush && (fcnt_q == '0);
  assign redirect_pc    = rpc_q;
  assign mispredict_cnt = mcnt_q;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (accept) begin
      unique case (1'b1)
        r_hit && resolve_taken: begin
          if (ctr_q[r_idx] != 2'b11) ctr_d[r_idx] = ctr_q[r_idx] + 2'd1;
          tgt_d[r_idx] = resolve_target;
        end
        r_hit && !resolve_taken: begin
          if (ctr_q[r_idx] != 2'b00) ctr_d[r_idx] = ctr_q[r_idx] - 2'd1;
        end
        !r_hit && resolve_taken: begin
          valid_d[r_idx] = 1'b1;
          tag_d[r_idx]   = r_tag;
          tgt_d[r_idx]   = resolve_target;
          ctr_d[r_idx]   = 2'b10;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    rpc_d   = rpc_q;
    mcnt_d  = mcnt_q;
    unique case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d = FLUSH;
          fcnt_d  = '0;
          rpc_d   = resolve_taken ? resolve_target : resolve_pc + 32'd4;
          mcnt_d  = mcnt_q + 32'd1;
        end
      end
      FLUSH: begin
        if (fcnt_q == FC_LAST) state_d = IDLE;
        else                   fcnt_d  = fcnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      rpc_q   <= '0;
      mcnt_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b00;
      end
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      rpc_q   <= rpc_d;
      mcnt_q  <= mcnt_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed scenarios with literal
// expectations, then random traffic against a behavioural model.
module tb_branch_predict_unit;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fetch_pc = 32'h0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        resolve_valid = 1'b0;
  logic [31:0] resolve_pc = 32'h0;
  logic        resolve_taken = 1'b0;
  logic [31:0] resolve_target = 32'h0;
  logic        resolve_pred_taken = 1'b0;
  logic [31:0] resolve_pred_target = 32'h0;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mispredict_cnt;

  branch_predict_unit #(.IDX_BITS(4), .FLUSH_CYCLES(FC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .fetch_pc            (fetch_pc),
    .pred_taken          (pred_taken),
    .pred_target         (pred_target),
    .resolve_valid       (resolve_valid),
    .resolve_pc          (resolve_pc),
    .resolve_taken       (resolve_taken),
    .resolve_target      (resolve_target),
    .resolve_pred_taken  (resolve_pred_taken),
    .resolve_pred_target (resolve_pred_target),
    .flush               (flush),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .mispredict_cnt      (mispredict_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  // Behavioural model: table as plain arrays, FSM as a countdown.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_left  = 0;
  logic [31:0] m_rpc   = 0;
  logic [31:0] m_cnt   = 0;

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = int'(pc[5:2]);
    return m_valid[i] && (m_tag[i] == pc[31:6]);
  endfunction

  function automatic bit m_ptaken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[int'(pc[5:2])] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_ptaken(pc) ? m_tgt[int'(pc[5:2])] : pc + 32'd4;
  endfunction

  always @(posedge clk) begin
    int i;
    bit mp;
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 0;
        m_ctr[k]   = 0;
      end
      m_left = 0;
      m_rpc  = 0;
      m_cnt  = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
    end else if (resolve_valid) begin
      i  = int'(resolve_pc[5:2]);
      mp = (resolve_taken != resolve_pred_taken) ||
           (resolve_taken && resolve_target != resolve_pred_target);
      if (m_hit(resolve_pc)) begin
        if (resolve_taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = resolve_target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (resolve_taken) begin
        m_valid[i] = 1;
        m_tag[i]   = resolve_pc[31:6];
        m_tgt[i]   = resolve_target;
        m_ctr[i]   = 2;
      end
      if (mp) begin
        m_left = FC;
        m_rpc  = resolve_taken ? resolve_target : resolve_pc + 32'd4;
        m_cnt  = m_cnt + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_pred_taken", 32'(pred_taken),
        32'(!rst && m_ptaken(fetch_pc)));
    chk("m_pred_target", pred_target,
        (!rst && m_ptaken(fetch_pc)) ? m_ptgt(fetch_pc) : fetch_pc + 32'd4);
    chk("m_flush", 32'(flush), 32'(m_left > 0));
    chk("m_redirect_valid", 32'(redirect_valid), 32'(m_left == FC));
    chk("m_redirect_pc", redirect_pc, m_rpc);
    chk("m_cnt", mispredict_cnt, m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic res(input logic [31:0] pc, input logic t,
                     input logic [31:0] tg, input logic pt,
                     input logic [31:0] ptg);
    resolve_valid       = 1'b1;
    resolve_pc          = pc;
    resolve_taken       = t;
    resolve_target      = tg;
    resolve_pred_taken  = pt;
    resolve_pred_target = ptg;
  endtask

  task automatic look(input string n, input logic [31:0] pc,
                      input logic t, input logic [31:0] tg);
    fetch_pc = pc;
    #1;
    chk({n, "_taken"}, 32'(pred_taken), 32'(t));
    chk({n, "_target"}, pred_target, tg);
  endtask

  initial begin
    logic [31:0] pc;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    look("reset_lookup", 32'h40, 1'b0, 32'h44);
    chk("reset_flush", 32'(flush), 32'd0);
    chk("reset_cnt", mispredict_cnt, 32'd0);

    res(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    tick();
    resolve_valid = 1'b0;
    #1;
    chk("mp1_flush", 32'(flush), 32'd1);
    chk("mp1_rv", 32'(redirect_valid), 32'd1);
    chk("mp1_rpc", redirect_pc, 32'h100);
    chk("mp1_cnt", mispredict_cnt, 32'd1);
    tick();
    #1;
    chk("mp1_flush2", 32'(flush), 32'd1);
    chk("mp1_rv2", 32'(redirect_valid), 32'd0);
    tick();
    chk("mp1_flush_done", 32'(flush), 32'd0);
    look("alloc", 32'h40, 1'b1, 32'h100);

    res(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    tick();
    resolve_valid = 1'b0;
    #1;
    chk("nt_rpc", redirect_pc, 32'h44);
    chk("nt_cnt", mispredict_cnt, 32'd2);
    tick();
    tick();
    look("ctr01", 32'h40, 1'b0, 32'h44);
    for (int k = 0; k < 3; k++) begin
      res(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      tick();
      chk("taken_noflush", 32'(flush), 32'd0);
    end
    res(32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
    tick();
    resolve_valid = 1'b0;
    look("sat11_dec", 32'h40, 1'b1, 32'h100);

    res(32'h440, 1'b1, 32'h300, 1'b0, 32'h444);
    tick();
    resolve_valid = 1'b0;
    tick();
    tick();
    look("alias_old", 32'h40, 1'b0, 32'h44);
    look("alias_new", 32'h440, 1'b1, 32'h300);

    res(32'h440, 1'b1, 32'h100, 1'b1, 32'h200);
    tick();
    res(32'h440, 1'b1, 32'h500, 1'b0, 32'h444);
    #1;
    chk("tgt_rpc", redirect_pc, 32'h100);
    chk("tgt_cnt", mispredict_cnt, 32'd4);
    tick();
    resolve_valid = 1'b0;
    #1;
    chk("wrongpath_cnt", mispredict_cnt, 32'd4);
    tick();
    look("wrongpath_entry", 32'h440, 1'b1, 32'h100);

    res(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    tick();
    resolve_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid_flush_before", 32'(flush), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid_flush", 32'(flush), 32'd0);
    chk("rstmid_rv", 32'(redirect_valid), 32'd0);
    chk("rstmid_cnt", mispredict_cnt, 32'd0);
    chk("rstmid_rpc", redirect_pc, 32'd0);
    look("rstmid_lookup", 32'h40, 1'b0, 32'h44);

    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 199) == 0);
      fetch_pc      = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2);
      pc            = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2);
      resolve_valid = $urandom_range(0, 1) == 1;
      resolve_pc     = pc;
      resolve_taken  = $urandom_range(0, 1) == 1;
      resolve_target = 32'h1000 + 32'($urandom_range(0, 3)) * 4;
      if ($urandom_range(0, 2) != 0) begin
        resolve_pred_taken  = m_ptaken(pc);
        resolve_pred_target = m_ptgt(pc);
      end else begin
        resolve_pred_taken  = $urandom_range(0, 1) == 1;
        resolve_pred_target = 32'h1000 + 32'($urandom_range(0, 3)) * 4;
      end
      tick();
    end
    rst = 1'b0;
    resolve_valid = 1'b0;
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
